dac_tx: RTL and testbench

- Output-side transmitter for the biquad filter datapath.
- Each strobe captures one signed fixed-point sample (same size/pf/mag format as the filter output).
- The sample is saturated to ±1.0 full scale and converted to an offset-binary DAC code.
- The code is shifted out MSB-first over a 3-wire serial DAC interface (SYNC_n/SCLK/DIN, 16-bit frame).
- The start strobe is tied to the same EN that clocks the filter's output register.

---
 rtl/dac_tx.sv | 140 ++++++++++++++
 tb/tb_dac_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_tx.sv
// Serial DAC transmitter: saturates a signed fixed-point sample to +/-1.0, converts it
// to offset binary and shifts it out MSB-first on a SYNC_n/SCLK/DIN frame.
module dac_tx #(
  parameter int size       = 22,
  parameter int pf         = 14,
  parameter int mag        = 7,
  parameter int dac_bits   = 12,
  parameter int frame_bits = 16,
  parameter int clk_div    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [size-1:0] y,
  input  logic                  start,
  output logic                  sclk,
  output logic                  sync_n,
  output logic                  din,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  sat,
  output logic [dac_bits-1:0]   dac_code
);

  // state | meaning
  // IDLE  | waiting for a capture strobe
  // SHIFT | frame in flight, sync_n low, one SCLK period per bit
  // QUIET | sync_n high for clk_div cycles, done on the last one
  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  localparam int cnt_w = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int bit_w = $clog2(frame_bits + 1);
  localparam logic [cnt_w-1:0] div_reload = cnt_w'(clk_div - 1);
  localparam logic signed [size-1:0] pos_fs = size'((64'sd1 <<< pf) - 64'sd1);
  localparam logic signed [size-1:0] neg_fs = size'(-(64'sd1 <<< pf));

  if (size != 1 + mag + pf) begin : g_bad_format
    $error("dac_tx: size must equal 1 + mag + pf");
  end
  if (pf < dac_bits - 1) begin : g_bad_res
    $error("dac_tx: pf must be at least dac_bits-1");
  end

  state_t                state;
  logic [cnt_w-1:0]      div_cnt;
  logic [bit_w-1:0]      bits_left;
  logic [frame_bits-1:0] shreg;

  logic signed [size-1:0] clamped;
  logic                   clip;
  logic [dac_bits-1:0]    code_next;
  logic [frame_bits-1:0]  frame_word;
  logic                   accept;

  always_comb begin
    clamped = y;
    clip    = 1'b0;
    if (y > pos_fs) begin
      clamped = pos_fs;
      clip    = 1'b1;
    end else if (y < neg_fs) begin
      clamped = neg_fs;
      clip    = 1'b1;
    end
    // Dropping the low fraction bits truncates toward -inf; flipping the MSB gives offset binary.
    code_next = clamped[pf -: dac_bits];
    code_next[dac_bits-1] = ~code_next[dac_bits-1];
    frame_word = frame_bits'(code_next);
  end

  // The done cycle is the last QUIET cycle, so a strobe there starts the next frame with no gap.
  assign accept = start && (!busy || done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bits_left <= '0;
      shreg     <= '0;
      sclk      <= 1'b1;
      sync_n    <= 1'b1;
      din       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      sat       <= 1'b0;
      dac_code  <= '0;
    end else begin
      done    <= 1'b0;
      overrun <= start && busy && !done;
      if (accept) begin
        dac_code  <= code_next;
        sat       <= clip;
        shreg     <= frame_word;
        din       <= frame_word[frame_bits-1];
        sclk      <= 1'b1;
        sync_n    <= 1'b0;
        busy      <= 1'b1;
        div_cnt   <= div_reload;
        bits_left <= bit_w'(frame_bits - 1);
        state     <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            if (div_cnt == '0) begin
              div_cnt <= div_reload;
              if (sclk) begin
                sclk <= 1'b0;
              end else if (bits_left == '0) begin
                state  <= QUIET;
                sync_n <= 1'b1;
                sclk   <= 1'b1;
                din    <= 1'b0;
                done   <= (clk_div == 1);
              end else begin
                sclk      <= 1'b1;
                shreg     <= shreg << 1;
                din       <= shreg[frame_bits-2];
                bits_left <= bits_left - 1'b1;
              end
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          QUIET: begin
            if (div_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              div_cnt <= div_cnt - 1'b1;
              if (div_cnt == cnt_w'(1)) done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_tx.sv
// Bench for dac_tx: scoreboard of expected frames checked by DAC receiver models sampling
// DIN on SCLK falling edges, for a default build and a clk_div=1 build.
module tb_dac_tx;
  localparam int F = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic signed [21:0] y = '0, y1 = '0;
  logic start = 1'b0, start1 = 1'b0;
  logic sclk, sync_n, din, busy, done, overrun, sat;
  logic sclk1, sync_n1, din1, busy1, done1, overrun1, sat1;
  logic [11:0] dac_code, dac_code1;

  dac_tx u_dut (
    .clk(clk), .rst(rst), .y(y), .start(start),
    .sclk(sclk), .sync_n(sync_n), .din(din), .busy(busy), .done(done),
    .overrun(overrun), .sat(sat), .dac_code(dac_code)
  );

  dac_tx #(.clk_div(1)) u_dut1 (
    .clk(clk), .rst(rst), .y(y1), .start(start1),
    .sclk(sclk1), .sync_n(sync_n1), .din(din1), .busy(busy1), .done(done1),
    .overrun(overrun1), .sat(sat1), .dac_code(dac_code1)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // DAC receiver model, default build
  logic p_sclk = 1'b1, p_sync = 1'b1, abort_ok = 1'b0;
  logic [15:0] rx_word = '0;
  int rx_bits = 0, low_len = 0, high_len = 0, last_high = 0;

  always @(negedge clk) begin
    if (!sync_n && p_sclk && !sclk) begin
      rx_word = {rx_word[14:0], din};
      rx_bits++;
    end
    if (!sync_n) low_len++;
    if (sync_n && !p_sync) begin
      if (abort_ok) abort_ok = 1'b0;
      else begin
        check("frame_len", rx_bits, F);
        check("sync_low", low_len, 2 * F * D);
        check("sb_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("frame", rx_word, exp_q.pop_front());
      end
      rx_word = '0;
      rx_bits = 0;
      low_len = 0;
    end
    if (!sync_n && p_sync) begin
      last_high = high_len;
      high_len = 0;
    end
    if (sync_n) high_len++;
    p_sclk = sclk;
    p_sync = sync_n;
  end

  // DAC receiver model, clk_div=1 build
  logic p_sclk1 = 1'b1, p_sync1 = 1'b1;
  logic [15:0] rx_word1 = '0;
  int rx_bits1 = 0;

  always @(negedge clk) begin
    if (!sync_n1 && p_sclk1 && !sclk1) begin
      rx_word1 = {rx_word1[14:0], din1};
      rx_bits1++;
    end
    if (sync_n1 && !p_sync1) begin
      check("frame1_len", rx_bits1, F);
      check("sb1_avail", exp_q1.size() > 0, 1);
      if (exp_q1.size() > 0) check("frame1", rx_word1, exp_q1.pop_front());
      rx_word1 = '0;
      rx_bits1 = 0;
    end
    p_sclk1 = sclk1;
    p_sync1 = sync_n1;
  end

  task automatic send(input logic signed [21:0] v, input logic [11:0] code, input logic s);
    @(negedge clk);
    y = v;
    start = 1'b1;
    exp_q.push_back(16'(code));
    @(negedge clk);
    start = 1'b0;
    check("dac_code", dac_code, code);
    check("sat", sat, s);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  logic signed [21:0] tv_y[5] = '{22'sd8192, -22'sd16384, 22'sd16384, -22'sd49152, 22'sd7};
  logic [11:0] tv_code[5] = '{12'hC00, 12'h000, 12'hFFF, 12'h000, 12'h800};
  logic tv_sat[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, dpos, n, bad;
    logic ps;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 1);
    check("rst_sync_n", sync_n, 1);
    check("rst_din", din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sat", sat, 0);
    check("rst_code", dac_code, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // zero sample: timing of busy, done and the frame
    send(22'sd0, 12'h800, 1'b0);
    len = 0;
    dpos = 0;
    while (busy && len < 300) begin
      len++;
      if (done) dpos = len;
      @(negedge clk);
    end
    check("busy_len", len, (2 * F + 1) * D);
    check("done_pos", dpos, (2 * F + 1) * D);
    wait_idle();

    for (int i = 0; i < 5; i++) begin
      send(tv_y[i], tv_code[i], tv_sat[i]);
      wait_idle();
    end

    // overrun mid-frame
    send(-22'sd8192, 12'h400, 1'b0);
    repeat (50) @(negedge clk);
    y = 22'sd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("overrun_hi", overrun, 1);
    @(negedge clk);
    check("overrun_lo", overrun, 0);
    check("overrun_code", dac_code, 12'h400);
    wait_idle();

    // back-to-back start on the done cycle
    send(22'sd4096, 12'hA00, 1'b0);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    y = -22'sd4096;
    start = 1'b1;
    exp_q.push_back(16'h0600);
    @(negedge clk);
    start = 1'b0;
    check("b2b_sync", sync_n, 0);
    check("b2b_busy", busy, 1);
    check("b2b_code", dac_code, 12'h600);
    @(negedge clk);
    check("b2b_gap", last_high, D);
    wait_idle();

    // reset mid-SHIFT
    send(22'sd100, 12'h80C, 1'b0);
    repeat (70) @(negedge clk);
    abort_ok = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_sync_n", sync_n, 1);
    check("abort_sclk", sclk, 1);
    check("abort_din", din, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    send(-22'sd1, 12'h7FF, 1'b0);
    wait_idle();

    // clk_div=1 build
    @(negedge clk);
    y1 = 22'sd16384;
    start1 = 1'b1;
    exp_q1.push_back(16'h0FFF);
    @(negedge clk);
    start1 = 1'b0;
    check("div1_code", dac_code1, 12'hFFF);
    check("div1_sat", sat1, 1);
    len = 0;
    bad = 0;
    ps = sclk1;
    while (busy1 && len < 100) begin
      if (len > 0 && !sync_n1 && sclk1 == ps) bad++;
      ps = sclk1;
      len++;
      @(negedge clk);
    end
    check("div1_busy_len", len, 2 * F + 1);
    check("div1_sclk_toggle", bad, 0);
    repeat (3) @(negedge clk);

    check("sb_empty", exp_q.size(), 0);
    check("sb1_empty", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
